// File: rtl/ili9341_spi_slave.sv
// ili9341_spi_slave
// Panel-side receiver for the 4-wire SPI display link (mode 0, MSB first).
// The SPI lines are oversampled in the clk domain. Bytes are reassembled and
// tagged as command (dc=0) or parameter (dc=1), and each carries a parameter
// index.
//
// Build option: define ILI9341_SPI_SLAVE_READ_EN to compile in the Read
// Display ID responder (command 0x04 -> ID_VALUE on miso, MSB first).
// Without it, miso is tied low and 0x04 is an ordinary command.
//
// Ports
//   clk, rst     : system clock, synchronous active-high reset
//   sclk, mosi   : SPI clock (idle low) and data from the master
//   cs           : chip select, active low
//   dc           : 0 = command byte, 1 = parameter byte
//   lcd_reset_n  : panel hardware reset, active low (same effect as rst)
//   miso         : read data to the master
//   rx_byte/rx_dc/param_idx : received byte, its dc, its parameter index
//   rx_valid     : one-cycle strobe qualifying rx_byte/rx_dc/param_idx.
//                  There is no back-pressure; a consumer must take it that cycle.
//   cmd          : most recent command byte
//   frame_err    : one-cycle pulse when cs rises with 1-7 bits pending
module ili9341_spi_slave #(
   parameter logic [23:0] ID_VALUE    = 24'h009341,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   input  logic       dc,
   input  logic       lcd_reset_n,
   output logic       miso,
   output logic [7:0] rx_byte,
   output logic       rx_dc,
   output logic       rx_valid,
   output logic [7:0] cmd,
   output logic [3:0] param_idx,
   output logic       frame_err
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_READ = 2'd2} state_t;
   state_t state_q, state_d;

   // Synchronizer chain, bit order {lcd_reset_n, dc, cs, mosi, sclk}.
   // Reset to the idle line levels so no false edge appears on release.
   localparam logic [4:0] SYNC_IDLE = 5'b10100;
   logic [4:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      end else begin
         sync_q[0] <= {lcd_reset_n, dc, cs, mosi, sclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   logic sclk_s, mosi_s, cs_s, dc_s, lcd_rst_n_s;
   assign {lcd_rst_n_s, dc_s, cs_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];

   logic soft_rst;
   assign soft_rst = rst | ~lcd_rst_n_s;

   // Previous synchronized samples for edge detection. During a panel reset
   // sclk_d tracks sclk so release cannot fake a rise; cs_d is held high so
   // a master that keeps cs low through the reset is picked up again.
   logic sclk_d, cs_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else if (!lcd_rst_n_s) begin
         sclk_d <= sclk_s;
         cs_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   // FSM output decode
   logic active, in_read;
   always_comb begin
      active  = (state_q != ST_IDLE);
      in_read = (state_q == ST_READ);
   end

   logic [7:0] shreg_q;
   logic [2:0] bit_cnt_q;
   logic       done_q, done_dc_q, err_pend_q;
   logic       shift_en;
   logic [2:0] bits_after;
   logic       load_read, read_end;

   assign shift_en   = sclk_rise & active;
   // Bits pending once this cycle's rise (if any) is taken; wraps at 8.
   assign bits_after = bit_cnt_q + (shift_en ? 3'd1 : 3'd0);

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
         ST_SHIFT: if (load_read) state_d = ST_READ;
         ST_READ:  if (!load_read && read_end) state_d = ST_SHIFT;
         default:  state_d = ST_IDLE;
      endcase
      if (cs_rise) state_d = ST_IDLE;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (soft_rst) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Byte assembly. done_q marks a completed byte one cycle before the strobe,
   // so shreg_q holds all eight bits when it is copied out.
   always_ff @(posedge clk) begin
      if (soft_rst) begin
         shreg_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         done_q     <= 1'b0;
         done_dc_q  <= 1'b0;
         err_pend_q <= 1'b0;
         rx_byte    <= 8'h00;
         rx_dc      <= 1'b0;
         rx_valid   <= 1'b0;
         cmd        <= 8'h00;
         param_idx  <= 4'd0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= done_q;
         frame_err  <= err_pend_q;
         done_q     <= 1'b0;
         err_pend_q <= cs_rise & active & (bits_after != 3'd0);
         if (shift_en) begin
            shreg_q   <= {shreg_q[6:0], mosi_s};
            bit_cnt_q <= bits_after;
            if (bit_cnt_q == 3'd7) begin
               done_q    <= 1'b1;
               done_dc_q <= dc_s;
            end
         end
         if (cs_rise || !active) bit_cnt_q <= 3'd0;
         if (done_q) begin
            rx_byte <= shreg_q;
            rx_dc   <= done_dc_q;
            if (!done_dc_q) begin
               cmd       <= shreg_q;
               param_idx <= 4'd0;
            end
         end
         // The strobe shows the index of the byte itself; advance afterwards.
         if (rx_valid && rx_dc && param_idx != 4'd15) param_idx <= param_idx + 4'd1;
      end
   end

`ifdef ILI9341_SPI_SLAVE_READ_EN
   logic [4:0]  rd_cnt_q;   // sclk rises seen since the read started
   logic [23:0] id_sr_q;

   // Falls before the first read rise (the tail of the 0x04 byte) are ignored
   // so the master samples ID_VALUE[23] on its first read rise.
   assign load_read = done_q & ~done_dc_q & (shreg_q == 8'h04) & active & ~cs_rise;
   assign read_end  = sclk_fall & (rd_cnt_q == 5'd24);

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         miso     <= 1'b0;
         rd_cnt_q <= 5'd0;
         id_sr_q  <= 24'h0;
      end else if (load_read) begin
         miso     <= ID_VALUE[23];
         rd_cnt_q <= 5'd0;
         id_sr_q  <= ID_VALUE;
      end else if (in_read) begin
         if (sclk_rise && rd_cnt_q != 5'd24) rd_cnt_q <= rd_cnt_q + 5'd1;
         if (sclk_fall) begin
            if (rd_cnt_q == 5'd24) begin
               miso <= 1'b0;
            end else if (rd_cnt_q != 5'd0) begin
               id_sr_q <= {id_sr_q[22:0], 1'b0};
               miso    <= id_sr_q[22];
            end
         end
      end else begin
         miso     <= 1'b0;
         rd_cnt_q <= 5'd0;
      end
   end
`else
   logic unused_read;
   assign unused_read = ^{ID_VALUE, in_read};
   assign load_read   = 1'b0;
   assign read_end    = 1'b0;
   assign miso        = 1'b0;
`endif

endmodule

// File: tb/tb_ili9341_spi_slave.sv
module tb_ili9341_spi_slave;

   localparam int HALF = 6;   // sclk half period in clk cycles

   logic       clk = 1'b0;
   logic       rst, sclk, mosi, cs, dc, lcd_reset_n;
   logic       miso;
   logic [7:0] rx_byte;
   logic       rx_dc, rx_valid;
   logic [7:0] cmd;
   logic [3:0] param_idx;
   logic       frame_err;

   int total = 0;
   int bad = 0;
   int rv_cnt = 0;
   int ferr_cnt = 0;
   logic [12:0] exp_q[$];   // {byte, dc, param_idx}

   ili9341_spi_slave #(.ID_VALUE(24'h009341), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc),
      .lcd_reset_n(lcd_reset_n), .miso(miso), .rx_byte(rx_byte), .rx_dc(rx_dc),
      .rx_valid(rx_valid), .cmd(cmd), .param_idx(param_idx), .frame_err(frame_err)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_byte(input logic [7:0] b, input logic d, input logic [3:0] idx);
      exp_q.push_back({b, d, idx});
   endtask

   // Mode 0 master: set data while low, capture miso just before the rise.
   task automatic spi_bits(input logic [7:0] b, input int n, input logic d, output logic [7:0] cap);
      cap = 8'h00;
      dc  = d;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         clks(HALF);
         cap  = {cap[6:0], miso};
         sclk = 1'b1;
         clks(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic d);
      logic [7:0] cap;
      spi_bits(b, 8, d, cap);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      clks(HALF);
   endtask

   task automatic cs_high();
      clks(HALF);
      cs = 1'b1;
      clks(2 * HALF);
   endtask

   // scoreboard: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
         rv_cnt++;
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_strobe: got=%0h exp=none", {rx_byte, rx_dc, param_idx});
         end
         if (exp_q.size() != 0) check("strobe", {rx_byte, rx_dc, param_idx}, exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] cap;
      int rv0, fe0;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; lcd_reset_n = 1'b1;

      // reset with random line activity
      repeat (2) begin
         @(negedge clk);
         sclk = 1'($urandom_range(0, 1));
         mosi = 1'($urandom_range(0, 1));
         cs   = 1'($urandom_range(0, 1));
         dc   = 1'($urandom_range(0, 1));
      end
      sclk = 1'b0; cs = 1'b1;
      clks(1);
      check("rst_miso", miso, 0);
      check("rst_rx_byte", rx_byte, 0);
      check("rst_rx_dc", rx_dc, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_cmd", cmd, 8'h00);
      check("rst_param_idx", param_idx, 0);
      check("rst_frame_err", frame_err, 0);
      rst = 1'b0;
      // sclk activity with cs high must not produce bytes
      for (int i = 0; i < 10; i++) begin
         mosi = 1'($urandom_range(0, 1));
         clks(HALF); sclk = 1'b1; clks(HALF); sclk = 1'b0;
      end
      clks(4);
      check("idle_no_strobe", rv_cnt, 0);

      // command + one parameter
      expect_byte(8'h36, 1'b0, 4'd0);
      expect_byte(8'h48, 1'b1, 4'd0);
      cs_low();
      send(8'h36, 1'b0);
      send(8'h48, 1'b1);
      cs_high();
      check("cp_cmd", cmd, 8'h36);
      check("cp_param_idx", param_idx, 4'd1);
      check("cp_queue", exp_q.size(), 0);
      check("cp_strobes", rv_cnt, 2);
      check("cp_boundary_no_ferr", ferr_cnt, 0);

      // parameter index saturation
      expect_byte(8'hE0, 1'b0, 4'd0);
      for (int i = 0; i < 17; i++) expect_byte(8'(8'h10 + i), 1'b1, (i > 15) ? 4'd15 : 4'(i));
      cs_low();
      send(8'hE0, 1'b0);
      for (int i = 0; i < 17; i++) send(8'(8'h10 + i), 1'b1);
      cs_high();
      check("sat_cmd", cmd, 8'hE0);
      check("sat_param_idx", param_idx, 4'd15);
      check("sat_queue", exp_q.size(), 0);

      // Read Display ID
      expect_byte(8'h04, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) expect_byte(8'h00, 1'b1, 4'(i));
      cs_low();
      send(8'h04, 1'b0);
      spi_bits(8'h00, 8, 1'b1, cap);
`ifdef ILI9341_SPI_SLAVE_READ_EN
      check("id_byte0", cap, 8'h00);
      spi_bits(8'h00, 8, 1'b1, cap);
      check("id_byte1", cap, 8'h93);
      spi_bits(8'h00, 8, 1'b1, cap);
      check("id_byte2", cap, 8'h41);
`else
      check("id_byte0", cap, 8'h00);
      spi_bits(8'h00, 8, 1'b1, cap);
      check("id_byte1", cap, 8'h00);
      spi_bits(8'h00, 8, 1'b1, cap);
      check("id_byte2", cap, 8'h00);
`endif
      spi_bits(8'h00, 8, 1'b1, cap);
      check("id_after", cap, 8'h00);
      check("id_miso_idle", miso, 0);
      cs_high();
      check("id_cmd", cmd, 8'h04);
      check("id_queue", exp_q.size(), 0);

      // aborted byte
      rv0 = rv_cnt; fe0 = ferr_cnt;
      cs_low();
      spi_bits(8'hB7, 5, 1'b0, cap);
      cs_high();
      check("abort_ferr", ferr_cnt - fe0, 1);
      check("abort_no_strobe", rv_cnt - rv0, 0);
      expect_byte(8'h2C, 1'b0, 4'd0);
      expect_byte(8'h5A, 1'b1, 4'd0);
      cs_low();
      send(8'h2C, 1'b0);
      send(8'h5A, 1'b1);
      cs_high();
      check("abort_next_cmd", cmd, 8'h2C);
      check("abort_next_queue", exp_q.size(), 0);
      check("abort_ferr_once", ferr_cnt - fe0, 1);

      // panel reset mid-byte
      rv0 = rv_cnt; fe0 = ferr_cnt;
      cs_low();
      spi_bits(8'hA5, 3, 1'b0, cap);
      lcd_reset_n = 1'b0;
      clks(2);
      cs = 1'b1;
      clks(6);
      check("prst_rx_byte", rx_byte, 0);
      check("prst_rx_dc", rx_dc, 0);
      check("prst_cmd", cmd, 8'h00);
      check("prst_param_idx", param_idx, 0);
      check("prst_miso", miso, 0);
      lcd_reset_n = 1'b1;
      clks(6);
      check("prst_no_strobe", rv_cnt - rv0, 0);
      check("prst_no_ferr", ferr_cnt - fe0, 0);
      expect_byte(8'h11, 1'b0, 4'd0);
      cs_low();
      send(8'h11, 1'b0);
      cs_high();
      check("prst_next_cmd", cmd, 8'h11);
      check("prst_next_byte", rx_byte, 8'h11);
      check("prst_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
